fetch_unit: RTL and testbench

Instruction fetch stage for the 9-bit core. It owns the program counter, drives the instruction ROM address, and registers the returned word into an instruction register for the decode stage. It also handles start/done program control, relative branches, absolute jumps, stalls and halt detection. It sits directly upstream of the instruction ROM and directly upstream of decode.

---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the 9-bit core.
package core_pkg;
   localparam int        PC_W       = 7;
   localparam int        INSTR_W    = 9;
   localparam logic [8:0] HALT_INSTR = 9'h1FF;

   typedef logic [PC_W-1:0]    pc_t;
   typedef logic [INSTR_W-1:0] instr_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Control, ROM and decode-side signals of the fetch stage.
interface fetch_unit_if;
   import core_pkg::*;

   logic   start;
   logic   stall;
   logic   branch_en;
   pc_t    branch_off;
   logic   jump_en;
   pc_t    jump_target;
   pc_t    rom_addr;
   instr_t rom_instr;
   instr_t instr;
   pc_t    instr_pc;
   logic   instr_valid;
   logic   done;

   modport master (
      input  start, stall, branch_en, branch_off, jump_en, jump_target, rom_instr,
      output rom_addr, instr, instr_pc, instr_valid, done
   );

   modport slave (
      output start, stall, branch_en, branch_off, jump_en, jump_target, rom_instr,
      input  rom_addr, instr, instr_pc, instr_valid, done
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses the ROM and registers the word
// for decode; handles start/halt, relative branches, jumps and stalls.
module fetch_unit
   import core_pkg::*;
#(
   parameter pc_t START_ADDR = 7'd0
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   fetch_state_t r_state, w_state;
   pc_t          r_pc, w_pc;
   instr_t       r_instr, w_instr;
   pc_t          r_instr_pc, w_instr_pc;
   logic         r_valid, w_valid;
   logic         r_done, w_done;
   logic         w_redirect;
   pc_t          w_redir_pc;

   assign bus.rom_addr    = r_pc;
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instr_pc;
   assign bus.instr_valid = r_valid;
   assign bus.done        = r_done;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_pc       <= START_ADDR;
         r_instr    <= 9'd0;
         r_instr_pc <= 7'd0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_pc       <= w_pc;
         r_instr    <= w_instr;
         r_instr_pc <= w_instr_pc;
         r_valid    <= w_valid;
         r_done     <= w_done;
      end
   end

   // Redirects only apply to a live instruction; jump has priority
   assign w_redirect = r_valid & (bus.jump_en | bus.branch_en);
   assign w_redir_pc = bus.jump_en ? bus.jump_target : pc_t'(r_instr_pc + bus.branch_off);

   // Next-state and next-datapath logic
   always_comb begin
      w_state    = r_state;
      w_pc       = r_pc;
      w_instr    = r_instr;
      w_instr_pc = r_instr_pc;
      w_valid    = r_valid;
      w_done     = r_done;
      case (r_state)
         ST_IDLE, ST_HALTED: begin
            if (bus.start) begin
               w_pc    = START_ADDR;
               w_valid = 1'b0;
               w_done  = 1'b0;
               w_state = ST_RUN;
            end else begin
               w_valid = 1'b0;
            end
         end
         ST_RUN: begin
            if (bus.stall) begin
               w_state = ST_RUN;
            end else if (w_redirect) begin
               // The word fetched this cycle is squashed, even a halt word
               w_valid = 1'b0;
               w_pc    = w_redir_pc;
            end else begin
               w_instr    = bus.rom_instr;
               w_instr_pc = r_pc;
               w_valid    = 1'b1;
               if (bus.rom_instr == HALT_INSTR) begin
                  w_state = ST_DRAIN;
               end else begin
                  w_pc = pc_t'(r_pc + 7'd1);
               end
            end
         end
         ST_DRAIN: begin
            if (!bus.stall) begin
               w_valid = 1'b0;
               w_done  = 1'b1;
               w_state = ST_HALTED;
            end else begin
               w_state = ST_DRAIN;
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: ROM returns addr+1 except a planted halt word.
module tb_fetch_unit;
   import core_pkg::*;

   typedef struct packed {
      logic       v;
      logic [6:0] pc;
      logic [8:0] ins;
      logic       dn;
      logic       ra_en;
      logic [6:0] ra;
   } exp_t;

   logic   clk;
   logic   rst_n;
   int     vectors;
   int     miscompares;
   int     cycle;
   int     halt_at;
   exp_t   sb_q[$];

   fetch_unit_if bus();

   fetch_unit u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      if (int'(bus.rom_addr) == halt_at) bus.rom_instr = 9'h1FF;
      else                               bus.rom_instr = {2'b00, bus.rom_addr} + 9'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
      end
   endtask

   // Push the expectation, clock once, then pop and compare against the DUT
   task automatic cyc(input logic ev, input int epc, input logic edn, input int era);
      exp_t e;
      e.v     = ev;
      e.pc    = 7'(epc);
      e.ins   = (epc == halt_at) ? 9'h1FF : 9'(epc + 1);
      e.dn    = edn;
      e.ra_en = (era >= 0);
      e.ra    = 7'(era);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cycle++;
      e = sb_q.pop_front();
      check("instr_valid", 32'(bus.instr_valid), 32'(e.v));
      if (e.v) begin
         check("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
         check("instr", 32'(bus.instr), 32'(e.ins));
      end
      check("done", 32'(bus.done), 32'(e.dn));
      if (e.ra_en) check("rom_addr", 32'(bus.rom_addr), 32'(e.ra));
   endtask

   task automatic check_reset_vals();
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      check("rst_instr", 32'(bus.instr), 32'd0);
      check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      cycle           = 0;
      halt_at         = -1;
      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.stall       = 1'b0;
      bus.branch_en   = 1'b0;
      bus.branch_off  = 7'd0;
      bus.jump_en     = 1'b0;
      bus.jump_target = 7'd0;
      #2;
      check_reset_vals();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b0, 0, 1'b0, 0);
      cyc(1'b0, 0, 1'b0, 0);

      // Start, then sequential fetch with rom_addr one ahead
      bus.start = 1'b1;
      cyc(1'b0, 0, 1'b0, 0);
      bus.start = 1'b0;
      for (int i = 0; i <= 5; i++) cyc(1'b1, i, 1'b0, i + 1);

      // Branch -3 at pc 5, then again at pc 2 to wrap below zero
      bus.branch_en  = 1'b1;
      bus.branch_off = 7'h7D;
      cyc(1'b0, 0, 1'b0, 2);
      bus.branch_en = 1'b0;
      cyc(1'b1, 2, 1'b0, 3);
      bus.branch_en = 1'b1;
      cyc(1'b0, 0, 1'b0, 127);
      bus.branch_en = 1'b0;
      cyc(1'b1, 127, 1'b0, 0);
      for (int i = 0; i <= 10; i++) cyc(1'b1, i, 1'b0, i + 1);

      // Jump wins over a simultaneous branch
      bus.jump_en     = 1'b1;
      bus.jump_target = 7'd40;
      bus.branch_en   = 1'b1;
      bus.branch_off  = 7'd4;
      cyc(1'b0, 0, 1'b0, 40);
      bus.jump_en   = 1'b0;
      bus.branch_en = 1'b0;
      cyc(1'b1, 40, 1'b0, 41);
      cyc(1'b1, 41, 1'b0, 42);

      // Stall for three cycles with a pending jump held off until release
      bus.stall       = 1'b1;
      bus.jump_en     = 1'b1;
      bus.jump_target = 7'd60;
      for (int i = 0; i < 3; i++) cyc(1'b1, 41, 1'b0, 42);
      bus.stall = 1'b0;
      cyc(1'b0, 0, 1'b0, 60);
      bus.jump_en = 1'b0;
      cyc(1'b1, 60, 1'b0, 61);

      // Run into a halt word at address 12, with a stall and a jump during drain
      halt_at         = 12;
      bus.jump_en     = 1'b1;
      bus.jump_target = 7'd9;
      cyc(1'b0, 0, 1'b0, 9);
      bus.jump_en = 1'b0;
      for (int i = 9; i <= 11; i++) cyc(1'b1, i, 1'b0, i + 1);
      cyc(1'b1, 12, 1'b0, 12);
      bus.stall       = 1'b1;
      bus.jump_en     = 1'b1;
      bus.jump_target = 7'd50;
      cyc(1'b1, 12, 1'b0, 12);
      bus.stall = 1'b0;
      cyc(1'b0, 0, 1'b1, 12);
      bus.jump_en = 1'b0;
      cyc(1'b0, 0, 1'b1, 12);
      bus.stall = 1'b1;
      cyc(1'b0, 0, 1'b1, 12);

      // Restart from halted (stall ignored there); start while running is ignored
      bus.start = 1'b1;
      cyc(1'b0, 0, 1'b0, 0);
      bus.start = 1'b0;
      bus.stall = 1'b0;
      cyc(1'b1, 0, 1'b0, 1);
      cyc(1'b1, 1, 1'b0, 2);
      bus.start = 1'b1;
      cyc(1'b1, 2, 1'b0, 3);
      bus.start = 1'b0;

      // Halt word fetched in a redirect shadow must not halt; jump ignored in the bubble
      bus.jump_en     = 1'b1;
      bus.jump_target = 7'd10;
      cyc(1'b0, 0, 1'b0, 10);
      bus.jump_en = 1'b0;
      cyc(1'b1, 10, 1'b0, 11);
      cyc(1'b1, 11, 1'b0, 12);
      bus.jump_en     = 1'b1;
      bus.jump_target = 7'd20;
      cyc(1'b0, 0, 1'b0, 20);
      cyc(1'b1, 20, 1'b0, 21);
      bus.jump_en = 1'b0;
      cyc(1'b1, 21, 1'b0, 22);

      // Asynchronous reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      #2;
      rst_n = 1'b1;
      cyc(1'b0, 0, 1'b0, 0);
      cyc(1'b0, 0, 1'b0, 0);
      bus.start = 1'b1;
      cyc(1'b0, 0, 1'b0, 0);
      bus.start = 1'b0;
      cyc(1'b1, 0, 1'b0, 1);
      cyc(1'b1, 1, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
